// File: rtl/frogger_pkg.sv
// Frogger shared types: main state machine encodings
// and the widths of the status values.
package frogger_pkg;

  typedef enum logic [1:0] {
    AWAIT = 2'b00,
    PLAY  = 2'b01,
    END   = 2'b10,
    INIT  = 2'b11
  } game_state_e;

  localparam int LIVES_W = 3;
  localparam int TIME_W  = 6;
  localparam int SCORE_W = 10;

endpackage

// File: rtl/sc_tick_prescaler.sv
// One-second tick generator for the game timer.
// Counts while enabled; clear restarts the second.
module sc_tick_prescaler #(
  parameter int TICKS_PER_SECOND = 50000000
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int CW =
    (TICKS_PER_SECOND > 1) ? $clog2(TICKS_PER_SECOND) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICKS_PER_SECOND - 1);

  logic [CW-1:0] cnt;

  assign tick = enable && (cnt == LAST);

  // Phase counter: wraps on the tick, restarts on clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= tick ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/sc_game_status_controller.sv
// Lives, countdown timer and score keeper for Frogger.
// Feeds end-game and respawn to the main state machine.
module sc_game_status_controller
  import frogger_pkg::*;
#(
  parameter int TICKS_PER_SECOND = 50000000,
  parameter int LIVES_INIT       = 3,
  parameter int TIME_INIT        = 30,
  parameter int SCORE_STEP       = 10,
  parameter int SCORE_WIDTH      = SCORE_W
) (
  input  logic                   SC_MAIN_STATEMACHINE_CLOCK_50,
  input  logic                   SC_MAIN_STATEMACHINE_RESET_InHigh,
  input  logic [1:0]             STATUS_State_In,
  input  logic                   STATUS_Collision_InHigh,
  input  logic                   STATUS_Goal_InHigh,
  output logic                   STATUS_EndGame_OutLow,
  output logic                   STATUS_Respawn_OutHigh,
  output logic [LIVES_W-1:0]     STATUS_Lives_Out,
  output logic [TIME_W-1:0]      STATUS_Time_Out,
  output logic [SCORE_WIDTH-1:0] STATUS_Score_Out
);

  localparam int SW1 = SCORE_WIDTH + 1;
  localparam logic [LIVES_W-1:0] L_INIT = LIVES_W'(LIVES_INIT);
  localparam logic [TIME_W-1:0]  T_INIT = TIME_W'(TIME_INIT);
  localparam logic [SW1-1:0]     STEP   = SW1'(SCORE_STEP);

  logic                   clk, rst;
  game_state_e            st;
  logic                   coll_q, goal_q;
  logic                   coll_ev, goal_ev;
  logic                   alive, tick, timeout, loss;
  logic                   enable, clear;
  logic [LIVES_W-1:0]     lives, lives_d;
  logic [TIME_W-1:0]      time_q, time_d;
  logic [SCORE_WIDTH-1:0] score, score_d, score_sat;
  logic [SW1-1:0]         score_sum;
  logic                   end_n, end_d;
  logic                   resp, resp_d;

  assign clk = SC_MAIN_STATEMACHINE_CLOCK_50;
  assign rst = SC_MAIN_STATEMACHINE_RESET_InHigh;
  assign st  = game_state_e'(STATUS_State_In);

  assign coll_ev = STATUS_Collision_InHigh && !coll_q;
  assign goal_ev = STATUS_Goal_InHigh && !goal_q;
  assign alive   = (lives != '0);
  assign enable  = (st == PLAY) && alive;
  assign timeout = tick && (time_q == '0);
  assign loss    = coll_ev || (timeout && !goal_ev);

  assign score_sum = {1'b0, score} + STEP;
  assign score_sat = score_sum[SCORE_WIDTH] ?
                     '1 : score_sum[SCORE_WIDTH-1:0];

  sc_tick_prescaler #(
    .TICKS_PER_SECOND(TICKS_PER_SECOND)
  ) u_presc (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .clear  (clear),
    .tick   (tick)
  );

  // Next status: init load, then life loss > goal > timer.
  always_comb begin
    lives_d = lives;
    time_d  = time_q;
    score_d = score;
    end_d   = end_n;
    resp_d  = 1'b0;
    clear   = 1'b0;
    unique case (st)
      INIT: begin
        lives_d = L_INIT;
        time_d  = T_INIT;
        score_d = '0;
        end_d   = 1'b1;
        resp_d  = 1'b1;
        clear   = 1'b1;
      end
      PLAY: begin
        if (alive) begin
          if (loss) begin
            if (lives > LIVES_W'(1)) begin
              lives_d = lives - 1'b1;
              time_d  = T_INIT;
              resp_d  = 1'b1;
              clear   = 1'b1;
            end else begin
              lives_d = '0;
              end_d   = 1'b0;
            end
          end else if (goal_ev) begin
            score_d = score_sat;
            time_d  = T_INIT;
            resp_d  = 1'b1;
            clear   = 1'b1;
          end else if (tick) begin
            time_d = time_q - 1'b1;
          end
        end
      end
      default: begin
      end
    endcase
  end

  // Status registers and input edge detectors.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      coll_q <= 1'b0;
      goal_q <= 1'b0;
      lives  <= L_INIT;
      time_q <= T_INIT;
      score  <= '0;
      end_n  <= 1'b1;
      resp   <= 1'b0;
    end else begin
      coll_q <= STATUS_Collision_InHigh;
      goal_q <= STATUS_Goal_InHigh;
      lives  <= lives_d;
      time_q <= time_d;
      score  <= score_d;
      end_n  <= end_d;
      resp   <= resp_d;
    end
  end

  assign STATUS_EndGame_OutLow  = end_n;
  assign STATUS_Respawn_OutHigh = resp;
  assign STATUS_Lives_Out       = lives;
  assign STATUS_Time_Out        = time_q;
  assign STATUS_Score_Out       = score;

endmodule
